// File: rtl/alu_sched_if.sv
// ---------------------------------------------------------------------------
// alu_sched_if -- bundle of the handshake and bus signals of alu_sched.
//
// Groups:
//   REQ0_* / REQ1_*  : two command requesters (valid/ready, operands, fun)
//   ALU_*            : issue side towards a shared, registered ALU
//   RSP_*            : response channel (valid/ready, data, owner id, error)
//   BUSY             : scheduler is not idle
//
// Modports:
//   slave  : the scheduler's view (alu_sched)
//   master : the environment's view (requesters, ALU and response consumer)
// ---------------------------------------------------------------------------
interface alu_sched_if #(
  parameter int IN_WIDTH  = 8,
  parameter int FUN_WIDTH = 4,
  parameter int OUT_WIDTH = 16
);
  logic                 REQ0_VALID;
  logic                 REQ0_READY;
  logic [IN_WIDTH-1:0]  REQ0_A;
  logic [IN_WIDTH-1:0]  REQ0_B;
  logic [FUN_WIDTH-1:0] REQ0_FUN;

  logic                 REQ1_VALID;
  logic                 REQ1_READY;
  logic [IN_WIDTH-1:0]  REQ1_A;
  logic [IN_WIDTH-1:0]  REQ1_B;
  logic [FUN_WIDTH-1:0] REQ1_FUN;

  logic [IN_WIDTH-1:0]  ALU_A;
  logic [IN_WIDTH-1:0]  ALU_B;
  logic [FUN_WIDTH-1:0] ALU_FUN;
  logic                 ALU_EN;
  logic [OUT_WIDTH-1:0] ALU_OUT;
  logic                 ALU_OUT_VALID;

  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [OUT_WIDTH-1:0] RSP_DATA;
  logic                 RSP_ID;
  logic                 RSP_ERR;

  logic                 BUSY;

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    output REQ0_READY,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    output REQ1_READY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN,
    input  ALU_OUT, ALU_OUT_VALID,
    output RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR,
    input  RSP_READY,
    output BUSY
  );

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    input  REQ0_READY,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    input  REQ1_READY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN,
    output ALU_OUT, ALU_OUT_VALID,
    input  RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR,
    output RSP_READY,
    input  BUSY
  );
endinterface

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched -- two-requester scheduler in front of one shared ALU.
//
// Arbitrates between two requesters (round-robin on contention), issues one
// command at a time to the ALU with a single-cycle ALU_EN pulse, waits up to
// TMO_CYCLES cycles for ALU_OUT_VALID and returns the result on a
// valid/ready response channel tagged with the owning requester.
// Divide by zero is answered directly with an error response.
//
// Ports:
//   CLK  : clock
//   RST  : asynchronous active-low reset
//   bus  : alu_sched_if.slave (requesters, ALU issue/result, response, BUSY)
// ---------------------------------------------------------------------------
module alu_sched #(
  parameter int IN_WIDTH   = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int TMO_CYCLES = 4
) (
  input  logic     CLK,
  input  logic     RST,
  alu_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int                   CNT_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TMO_CYCLES - 1);
  localparam logic [FUN_WIDTH-1:0] FUN_DIV  = FUN_WIDTH'(3);

  state_t               state_q;
  logic                 prio_q;
  logic [IN_WIDTH-1:0]  a_q;
  logic [IN_WIDTH-1:0]  b_q;
  logic [FUN_WIDTH-1:0] fun_q;
  logic                 id_q;
  logic                 alu_en_q;
  logic [OUT_WIDTH-1:0] rsp_data_q;
  logic                 rsp_err_q;
  logic                 rsp_valid_q;
  logic [CNT_W-1:0]     cnt_q;

  // Grant selection: a lone requester wins, on contention PRIO decides.
  logic                 gnt_vld_d;
  logic                 gnt_id_d;
  logic [IN_WIDTH-1:0]  sel_a_d;
  logic [IN_WIDTH-1:0]  sel_b_d;
  logic [FUN_WIDTH-1:0] sel_fun_d;
  logic                 div_zero_d;

  always_comb begin
    gnt_vld_d  = (state_q == IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);
    gnt_id_d   = (bus.REQ0_VALID && bus.REQ1_VALID) ? prio_q : bus.REQ1_VALID;
    sel_a_d    = gnt_id_d ? bus.REQ1_A   : bus.REQ0_A;
    sel_b_d    = gnt_id_d ? bus.REQ1_B   : bus.REQ0_B;
    sel_fun_d  = gnt_id_d ? bus.REQ1_FUN : bus.REQ0_FUN;
    div_zero_d = (sel_fun_d == FUN_DIV) && (sel_b_d == '0);
  end

  assign bus.REQ0_READY = gnt_vld_d && !gnt_id_d;
  assign bus.REQ1_READY = gnt_vld_d &&  gnt_id_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      id_q        <= 1'b0;
      alu_en_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // ALU_EN is a pulse: only the IDLE->ISSUE transition raises it.
      alu_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            a_q    <= sel_a_d;
            b_q    <= sel_b_d;
            fun_q  <= sel_fun_d;
            id_q   <= gnt_id_d;
            prio_q <= ~gnt_id_d;
            if (div_zero_d) begin
              // Answered locally; the ALU never sees this command.
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              alu_en_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.ALU_OUT_VALID) begin
            rsp_data_q  <= bus.ALU_OUT;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == TMO_LAST) begin
            // TMO_CYCLES WAIT cycles without a result: give up.
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ALU_A     = a_q;
  assign bus.ALU_B     = b_q;
  assign bus.ALU_FUN   = fun_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ID    = id_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameters, one per line:
- IN_WIDTH, 8, operand width.
- FUN_WIDTH, 4, ALU function code width.
- OUT_WIDTH, 16, ALU result width.
- TMO_CYCLES, 4, maximum cycles to wait for ALU_OUT_VALID.

REQ-002 Ports, one per line:
- CLK  in  1  clock; reset RST, asynchronous, active-low; clock CLK.
- RST  in  1  asynchronous active-low reset.
- REQ0_VALID  in  1  requester 0 has a command.
- REQ0_READY  out  1  requester 0 command accepted this cycle.
- REQ0_A / REQ0_B  in  IN_WIDTH  requester 0 operands.
- REQ0_FUN  in  FUN_WIDTH  requester 0 function code.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_FUN: same for requester 1.
- ALU_A / ALU_B  out  IN_WIDTH  operands to the shared ALU.
- ALU_FUN  out  FUN_WIDTH  function code to the ALU.
- ALU_EN  out  1  ALU enable, one-cycle pulse per issued command.
- ALU_OUT  in  OUT_WIDTH  ALU registered result.
- ALU_OUT_VALID  in  1  ALU result valid.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  OUT_WIDTH  result.
- RSP_ID  out  1  requester index owning the response.
- RSP_ERR  out  1  command rejected or timed out.
- BUSY  out  1  high in any state other than IDLE.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT, RESP; only one command is in flight at a time.
REQ-004 In IDLE the block arbitrates. At most one REQx_READY is high, driven combinationally, and only in IDLE with the matching REQx_VALID high.
- Sole valid requester: granted.
- Both valid: the requester named by the round-robin pointer PRIO is granted.
REQ-005 On acceptance (REQx_VALID && REQx_READY):
- A, B, FUN and ID are latched.
- PRIO is set to the other requester.
- With only one requester valid, PRIO still toggles away from the granted one.
REQ-006 If the accepted FUN is 4'b0011 (divide) and B = 0:
- No ALU issue.
- Next state is RESP with RSP_DATA = 0, RSP_ERR = 1.
- Latency: RSP_VALID high one cycle after acceptance.
REQ-007 Otherwise the next state is ISSUE. In ISSUE, ALU_EN = 1 for exactly one cycle with ALU_A/ALU_B/ALU_FUN equal to the latched values; the next state is WAIT.
REQ-008 ALU_A/ALU_B/ALU_FUN hold their last latched values in all states; ALU_EN = 0 outside ISSUE.
REQ-009 In WAIT, the first cycle with ALU_OUT_VALID = 1 captures ALU_OUT into RSP_DATA with RSP_ERR = 0 and moves to RESP.
- Nominal latency: acceptance at cycle 0, ALU_EN at cycle 1, capture at cycle 2, RSP_VALID at cycle 3.
REQ-010 A WAIT cycle counter counts from 0. If TMO_CYCLES WAIT cycles elapse without ALU_OUT_VALID, the FSM moves to RESP with RSP_DATA = 0, RSP_ERR = 1.
REQ-011 In RESP:
- RSP_VALID = 1 with RSP_DATA/RSP_ID/RSP_ERR stable until RSP_READY = 1.
- On that cycle the FSM returns to IDLE.
- No new request is accepted in the same cycle; the earliest next acceptance is the following cycle.
REQ-012 ALU_OUT_VALID asserted in IDLE, ISSUE or RESP is ignored.
REQ-013 REQx operand changes after acceptance do not affect the in-flight command.

Reset
REQ-014 While RST = 0, asynchronously:
- State = IDLE, PRIO = 0.
- Latched operands, ALU_A/ALU_B/ALU_FUN, RSP_DATA, RSP_ID, RSP_ERR and the WAIT counter = 0.
- RSP_VALID, ALU_EN, BUSY = 0.
REQ-015 Reset asserted mid-operation abandons the in-flight command with no response generated; the first post-reset grant with both requesters valid goes to requester 0.

Verification
REQ-016 Single requester: REQ0 A=8'd5, B=8'd3, FUN=4'b0000; ALU model returns 16'd8 one cycle after ALU_EN -> RSP_VALID at cycle 3, RSP_DATA=8, RSP_ID=0, RSP_ERR=0.
REQ-017 Contention: both requesters valid continuously with RSP_READY=1 -> grants alternate 0,1,0,1; each REQx_READY is a single-cycle pulse; the two READYs are never high together.
REQ-018 Divide by zero: REQ1 A=8'd9, B=8'd0, FUN=4'b0011 -> ALU_EN never asserted; next cycle RSP_VALID=1, RSP_DATA=0, RSP_ID=1, RSP_ERR=1.
REQ-019 Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID -> RSP fields stable, no REQx_READY, BUSY=1; RSP_READY=1 -> IDLE next cycle.
REQ-020 Timeout: ALU model never asserts ALU_OUT_VALID -> after 4 WAIT cycles RSP_VALID=1, RSP_ERR=1, RSP_DATA=0.
REQ-021 Reset mid-WAIT: RST low during WAIT -> all outputs 0 immediately; after release, both requesters valid -> requester 0 granted first.
